// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types, default size and bit-reversal helper
// Purpose : common definitions for the FFT address-generation slice.
// Contents: LOG2N_DEFAULT, fft_addr_t / fft_tw_t / fft_stage_t, bitrev().
package fft_pkg;

  localparam int LOG2N_DEFAULT = 11;

  typedef logic [LOG2N_DEFAULT-1:0] fft_addr_t;
  typedef logic [LOG2N_DEFAULT-2:0] fft_tw_t;
  typedef logic [3:0]               fft_stage_t;

  // Reverses the low nbits of v; bits above nbits come back as zero.
  function automatic fft_addr_t bitrev(input fft_addr_t v, input int nbits);
    fft_addr_t r;
    fft_addr_t vv;
    r  = '0;
    vv = v;
    for (int i = 0; i < LOG2N_DEFAULT; i++) begin
      if (i < nbits) begin
        r  = {r[LOG2N_DEFAULT-2:0], vv[0]};
        vv = vv >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_map.sv
// rtl/fft_bfly_map.sv - combinational butterfly (b, s) to (top, bot, tw) mapping
// Purpose : address/twiddle mapping for one radix-2 DIT butterfly.
// Ports   : i_b   butterfly index within the stage
//           i_s   stage number
//           o_top address of operand a
//           o_bot address of operand b (top + 2^s)
//           o_tw  twiddle exponent k of W_N^k
module fft_bfly_map
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic [LOG2N-2:0] i_b,
  input  fft_stage_t       i_s,
  output logic [LOG2N-1:0] o_top,
  output logic [LOG2N-1:0] o_bot,
  output logic [LOG2N-2:0] o_tw
);

  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] tw_full;
  logic [3:0]       tw_sh;

  always_comb begin
    b_ext = {1'b0, i_b};
    span  = LOG2N'(1) << i_s;
    grp   = b_ext >> i_s;
    pos   = b_ext & (span - LOG2N'(1));
    // Insert a zero at bit s: group index moves up one place above pos.
    o_top = (grp << (i_s + 4'd1)) | pos;
    o_bot = o_top + span;
    // pos < 2^s, so shifting by LOG2N-1-s always stays within LOG2N-1 bits.
    tw_sh   = 4'(LOG2N - 1) - i_s;
    tw_full = pos << tw_sh;
    o_tw    = tw_full[LOG2N-2:0];
  end

endmodule

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - in-place radix-2 DIT FFT butterfly address generator
// Purpose : tracks butterfly index b and stage s, drives operand address,
//           write enable and twiddle index, and flags end of stage / transform.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_start          clear b and s (priority over enable)
//           i_addr_enable    advance to next butterfly
//           i_addr_writemode 0 read, 1 write-back (registered onto o_we)
//           i_mem_num        0 top operand, 1 bottom operand
//           o_addr, o_we, o_tw_idx  registered, 1-cycle latency
//           o_stage          current stage
//           o_stage_done, o_fft_done  registered one-cycle pulses
//           FFT_ADDR_BITREV_EN: adds i_load_valid, o_load_addr, o_load_done
//           (bit-reversed input load addressing).
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_addr_enable,
  input  logic             i_addr_writemode,
  input  logic             i_mem_num,
`ifdef FFT_ADDR_BITREV_EN
  input  logic             i_load_valid,
  output logic [LOG2N-1:0] o_load_addr,
  output logic             o_load_done,
`endif
  output logic [LOG2N-1:0] o_addr,
  output logic             o_we,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic [3:0]       o_stage,
  output logic             o_stage_done,
  output logic             o_fft_done
);

  localparam logic [LOG2N-2:0] B_LAST = '1;
  localparam fft_stage_t       S_LAST = fft_stage_t'(LOG2N - 1);

  logic [LOG2N-2:0] b_q, b_d;
  fft_stage_t       s_q, s_d;
  logic [LOG2N-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic             stage_done_q, stage_done_d;
  logic             fft_done_q, fft_done_d;

  logic [LOG2N-1:0] map_top;
  logic [LOG2N-1:0] map_bot;
  logic [LOG2N-2:0] map_tw;

  fft_bfly_map #(.LOG2N(LOG2N)) u_map (
    .i_b   (b_q),
    .i_s   (s_q),
    .o_top (map_top),
    .o_bot (map_bot),
    .o_tw  (map_tw)
  );

  always_comb begin
    b_d          = b_q;
    s_d          = s_q;
    stage_done_d = 1'b0;
    fft_done_d   = 1'b0;
    addr_d       = i_mem_num ? map_bot : map_top;
    we_d         = i_addr_writemode;
    tw_d         = map_tw;

    if (i_start) begin
      b_d = '0;
      s_d = '0;
    end else if (i_addr_enable) begin
      if (b_q == B_LAST) begin
        b_d          = '0;
        stage_done_d = 1'b1;
        if (s_q == S_LAST) begin
          s_d        = '0;
          fft_done_d = 1'b1;
        end else begin
          s_d = s_q + 4'd1;
        end
      end else begin
        b_d = b_q + (LOG2N-1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      b_q          <= '0;
      s_q          <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      tw_q         <= '0;
      stage_done_q <= 1'b0;
      fft_done_q   <= 1'b0;
    end else begin
      b_q          <= b_d;
      s_q          <= s_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      tw_q         <= tw_d;
      stage_done_q <= stage_done_d;
      fft_done_q   <= fft_done_d;
    end
  end

  assign o_addr       = addr_q;
  assign o_we         = we_q;
  assign o_tw_idx     = tw_q;
  assign o_stage      = s_q;
  assign o_stage_done = stage_done_q;
  assign o_fft_done   = fft_done_q;

`ifdef FFT_ADDR_BITREV_EN
  logic [LOG2N-1:0] load_cnt_q, load_cnt_d;
  logic [LOG2N-1:0] load_addr_q, load_addr_d;
  logic             load_done_q, load_done_d;
  fft_addr_t        load_rev;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    load_addr_d = load_addr_q;
    load_done_d = 1'b0;
    load_rev    = bitrev(fft_addr_t'(load_cnt_q), LOG2N);
    if (i_start) begin
      load_cnt_d = '0;
    end else if (i_load_valid) begin
      load_addr_d = load_rev[LOG2N-1:0];
      // Counter is exactly LOG2N bits, so the N-th sample wraps it to 0.
      load_cnt_d  = load_cnt_q + LOG2N'(1);
      load_done_d = (load_cnt_q == '1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      load_cnt_q  <= '0;
      load_addr_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      load_addr_q <= load_addr_d;
      load_done_q <= load_done_d;
    end
  end

  assign o_load_addr = load_addr_q;
  assign o_load_done = load_done_q;
`endif

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb/tb_fft_addr_gen.sv - scoreboard testbench for fft_addr_gen (N = 16)
module tb_fft_addr_gen;

  localparam int LOG2N = 4;
  localparam int N     = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             i_addr_enable = 1'b0;
  logic             i_addr_writemode = 1'b0;
  logic             i_mem_num = 1'b0;
  logic             load_valid = 1'b0;
  logic [LOG2N-1:0] o_addr;
  logic             o_we;
  logic [LOG2N-2:0] o_tw_idx;
  logic [3:0]       o_stage;
  logic             o_stage_done;
  logic             o_fft_done;
`ifdef FFT_ADDR_BITREV_EN
  logic [LOG2N-1:0] o_load_addr;
  logic             o_load_done;
`endif

  fft_addr_gen #(.LOG2N(LOG2N)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_start          (i_start),
    .i_addr_enable    (i_addr_enable),
    .i_addr_writemode (i_addr_writemode),
    .i_mem_num        (i_mem_num),
`ifdef FFT_ADDR_BITREV_EN
    .i_load_valid     (load_valid),
    .o_load_addr      (o_load_addr),
    .o_load_done      (o_load_done),
`endif
    .o_addr           (o_addr),
    .o_we             (o_we),
    .o_tw_idx         (o_tw_idx),
    .o_stage          (o_stage),
    .o_stage_done     (o_stage_done),
    .o_fft_done       (o_fft_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int addr;
    int we;
    int tw;
    int stage;
    int sd;
    int fd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   sd_seen = 0;
  int   fd_seen = 0;
  int   mb = 0;
  int   ms = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference mapping in plain arithmetic terms.
  function automatic int m_top(input int b, input int s);
    int span = 2 ** s;
    return (b / span) * 2 * span + (b % span);
  endfunction

  function automatic int m_bot(input int b, input int s);
    return m_top(b, s) + 2 ** s;
  endfunction

  function automatic int m_tw(input int b, input int s);
    int span = 2 ** s;
    return (b % span) * ((N / 2) / span);
  endfunction

  function automatic int m_rev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic step(input logic en, input logic wm, input logic mn,
                      input logic st, input logic lv);
    exp_t e;
    @(negedge i_clk);
    i_addr_enable    = en;
    i_addr_writemode = wm;
    i_mem_num        = mn;
    i_start          = st;
    load_valid       = lv;
    e.addr = mn ? m_bot(mb, ms) : m_top(mb, ms);
    e.we   = int'(wm);
    e.tw   = m_tw(mb, ms);
    e.sd   = 0;
    e.fd   = 0;
    if (st) begin
      mb = 0;
      ms = 0;
    end else if (en) begin
      if (mb == N / 2 - 1) begin
        mb   = 0;
        e.sd = 1;
        if (ms == LOG2N - 1) begin
          ms   = 0;
          e.fd = 1;
        end else begin
          ms++;
        end
      end else begin
        mb++;
      end
    end
    e.stage = ms;
    q.push_back(e);
  endtask

  task automatic idle_rand();
    step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic en_n(input int k);
    for (int i = 0; i < k; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) idle_rand();
    end
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() > 0 && g < 20) begin
      @(posedge i_clk);
      #2;
      g++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, int'(o_addr), 0);
    chk({tag, "_we"}, int'(o_we), 0);
    chk({tag, "_tw"}, int'(o_tw_idx), 0);
    chk({tag, "_stage"}, int'(o_stage), 0);
    chk({tag, "_sdone"}, int'(o_stage_done), 0);
    chk({tag, "_fdone"}, int'(o_fft_done), 0);
  endtask

  // Monitor: one expected entry per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("addr", int'(o_addr), e.addr);
        chk("we", int'(o_we), e.we);
        chk("tw_idx", int'(o_tw_idx), e.tw);
        chk("stage", int'(o_stage), e.stage);
        chk("stage_done", int'(o_stage_done), e.sd);
        chk("fft_done", int'(o_fft_done), e.fd);
        sd_seen += int'(o_stage_done);
        fd_seen += int'(o_fft_done);
      end
    end
  end

  initial begin
    #27;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // b=0, s=0: top then bottom operand.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // s=1, b=5 and then s=3, b=7.
    en_n(13);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    en_n(18);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    en_n(1);
    drain();
    chk("stage_done_count_32", sd_seen, 4);
    chk("fft_done_count_32", fd_seen, 1);

    // start and enable together at b=3, s=2.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    en_n(19);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("stage_done_count_start", sd_seen, 6);
    chk("fft_done_count_start", fd_seen, 1);

    // Asynchronous reset mid-stage.
    en_n(5);
    drain();
    i_addr_enable = 1'b0;
    i_start       = 1'b0;
    i_rst_n       = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge i_clk);
    #1;
    chk_all_zero("midreset_hold");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mb = 0;
    ms = 0;

    // Random traffic with occasional restarts (sometimes colliding with enable).
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        idle_rand();
      end else begin
        en_n(1);
      end
    end
    drain();

`ifdef FFT_ADDR_BITREV_EN
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge i_clk);
      #1;
      chk("load_addr", int'(o_load_addr), m_rev(k));
      chk("load_done", int'(o_load_done), (k == N - 1) ? 1 : 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("load_done_clear", int'(o_load_done), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
